// File: rtl/decode_stage_hs.sv
// decode_stage_hs: valid/ready RV32I decode stage with a 2-entry skid buffer.
// The head (main) entry drives all decoded outputs. The skid entry absorbs
// the one instruction that may arrive while the head is stalled, so ready_o
// can be a plain register.
module decode_stage_hs #(
  parameter int unsigned          DWIDTH = 32,
  parameter int unsigned          AWIDTH = 32,
  parameter logic [DWIDTH-1:0]    NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        shamt_o,
  output logic [6:0]        funct7_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              illegal_o
);

  logic              main_vld_q, main_vld_d;
  logic [AWIDTH-1:0] main_pc_q, main_pc_d;
  logic [DWIDTH-1:0] main_insn_q, main_insn_d;
  logic              skid_vld_q, skid_vld_d;
  logic [AWIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [DWIDTH-1:0] skid_insn_q, skid_insn_d;
  logic              ready_q, ready_d;

  logic accept;
  logic pop;
  logic main_free;

  // Immediate generation by instruction format; unknown formats give zero.
  function automatic logic [DWIDTH-1:0] gen_imm(input logic [DWIDTH-1:0] insn);
    logic [DWIDTH-1:0] imm;
    case (insn[6:0])
      7'h03, 7'h13, 7'h67, 7'h73:
        imm = {{20{insn[31]}}, insn[31:20]};
      7'h23:
        imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      7'h63:
        imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      7'h37, 7'h17:
        imm = {insn[31:12], 12'b0};
      7'h6F:
        imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  // Legal when the low two bits mark a 32-bit encoding and the opcode is a base RV32I one.
  function automatic logic is_legal(input logic [DWIDTH-1:0] insn);
    logic ok;
    case (insn[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
      7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok & (insn[1:0] == 2'b11);
  endfunction

  assign accept    = valid_i & ready_q;
  assign pop       = main_vld_q & ready_i;
  assign main_free = ~main_vld_q | pop;

  // Next-state for the two entries: skid drains to main first, keeping FIFO order.
  always_comb begin
    main_vld_d  = main_vld_q;
    main_pc_d   = main_pc_q;
    main_insn_d = main_insn_q;
    skid_vld_d  = skid_vld_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_pc_d   = skid_pc_q;
        main_insn_d = skid_insn_q;
        skid_vld_d  = accept;
        if (accept) begin
          skid_pc_d   = pc_i;
          skid_insn_d = insn_i;
        end
      end else begin
        main_vld_d = accept;
        if (accept) begin
          main_pc_d   = pc_i;
          main_insn_d = insn_i;
        end
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_pc_d   = pc_i;
      skid_insn_d = insn_i;
    end
    if (flush_i) begin
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_pc_d   = '0;
      main_insn_d = NOP;
    end
    ready_d = ~skid_vld_d;
  end

  // Head entry, valids and ready; reset reloads the NOP into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_pc_q   <= '0;
      main_insn_q <= NOP;
      ready_q     <= 1'b1;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_pc_q   <= main_pc_d;
      main_insn_q <= main_insn_d;
      ready_q     <= ready_d;
    end
  end

  // Skid payload is only meaningful under skid_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_pc_q   <= skid_pc_d;
    skid_insn_q <= skid_insn_d;
  end

  assign ready_o   = ready_q;
  assign valid_o   = main_vld_q;
  assign pc_o      = main_pc_q;
  assign insn_o    = main_insn_q;
  assign opcode_o  = main_insn_q[6:0];
  assign rd_o      = main_insn_q[11:7];
  assign funct3_o  = main_insn_q[14:12];
  assign rs1_o     = main_insn_q[19:15];
  assign rs2_o     = main_insn_q[24:20];
  assign shamt_o   = main_insn_q[24:20];
  assign funct7_o  = main_insn_q[31:25];
  assign imm_o     = gen_imm(main_insn_q);
  assign illegal_o = main_vld_q & ~is_legal(main_insn_q);

endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: directed tests for the handshaked decode stage.
module tb_decode_stage_hs;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] pc_i;
  logic [31:0] insn_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  shamt_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        illegal_o;

  int total;
  int bad;

  decode_stage_hs dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .insn_i(insn_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .insn_o(insn_o),
    .opcode_o(opcode_o), .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .shamt_o(shamt_o), .funct7_o(funct7_o), .imm_o(imm_o),
    .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are read 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle, then drop valid_i.
  task automatic put(input logic [31:0] pc, input logic [31:0] insn);
    valid_i = 1'b1;
    pc_i    = pc;
    insn_i  = insn;
    step();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h want=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%h want=1", ready_o); end
    total++; if (insn_o !== 32'h00000013) begin bad++; $display("FAIL rst_insn got=%h want=00000013", insn_o); end
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_o); end
    total++; if (imm_o !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h want=0", imm_o); end
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%h want=0", illegal_o); end
    total++; if (opcode_o !== 7'h13) begin bad++; $display("FAIL rst_opcode got=%h want=13", opcode_o); end
  endtask

  task automatic test_decode();
    ready_i = 1'b1;
    put(32'h100, 32'hFFB10093);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL dec_valid got=%h want=1", valid_o); end
    total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL dec_pc got=%h want=100", pc_o); end
    total++; if (rd_o !== 5'd1) begin bad++; $display("FAIL dec_rd got=%0d want=1", rd_o); end
    total++; if (rs1_o !== 5'd2) begin bad++; $display("FAIL dec_rs1 got=%0d want=2", rs1_o); end
    total++; if (funct3_o !== 3'd0) begin bad++; $display("FAIL dec_funct3 got=%0d want=0", funct3_o); end
    total++; if (imm_o !== 32'hFFFFFFFB) begin bad++; $display("FAIL dec_imm got=%h want=FFFFFFFB", imm_o); end
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL dec_illegal got=%h want=0", illegal_o); end
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL dec_popped got=%h want=0", valid_o); end
  endtask

  task automatic test_immediates();
    ready_i = 1'b1;
    put(32'h104, 32'hFE000EE3);
    total++; if (imm_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_b got=%h want=FFFFFFFC", imm_o); end
    put(32'h108, 32'h123452B7);
    total++; if (imm_o !== 32'h12345000) begin bad++; $display("FAIL imm_u got=%h want=12345000", imm_o); end
    total++; if (rd_o !== 5'd5) begin bad++; $display("FAIL imm_u_rd got=%0d want=5", rd_o); end
    put(32'h10C, 32'h00112623);
    total++; if (imm_o !== 32'h0000000C) begin bad++; $display("FAIL imm_s got=%h want=0000000C", imm_o); end
    total++; if (rs2_o !== 5'd1) begin bad++; $display("FAIL imm_s_rs2 got=%0d want=1", rs2_o); end
    put(32'h110, 32'hFF9FF06F);
    total++; if (imm_o !== 32'hFFFFFFF8) begin bad++; $display("FAIL imm_j got=%h want=FFFFFFF8", imm_o); end
    put(32'h114, 32'h40B50533);
    total++; if (imm_o !== 32'h0) begin bad++; $display("FAIL imm_r got=%h want=0", imm_o); end
    total++; if (funct7_o !== 7'h20) begin bad++; $display("FAIL r_funct7 got=%h want=20", funct7_o); end
    total++; if (shamt_o !== 5'd11) begin bad++; $display("FAIL r_shamt got=%0d want=11", shamt_o); end
    step();
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    put(32'h200, 32'h00100093);
    total++; if (insn_o !== 32'h00100093 || valid_o !== 1'b1) begin bad++; $display("FAIL bp_a got=%h/%h want=00100093/1", insn_o, valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_a got=%h want=1", ready_o); end
    put(32'h204, 32'h00200113);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_b got=%h want=0", ready_o); end
    total++; if (insn_o !== 32'h00100093) begin bad++; $display("FAIL bp_hold_b got=%h want=00100093", insn_o); end
    valid_i = 1'b1;
    pc_i    = 32'h208;
    insn_i  = 32'h00300193;
    step();
    total++; if (insn_o !== 32'h00100093 || pc_o !== 32'h200) begin bad++; $display("FAIL bp_hold_c got=%h pc=%h want=00100093 pc=200", insn_o, pc_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready_c got=%h want=0", ready_o); end
    ready_i = 1'b1;
    step();
    total++; if (insn_o !== 32'h00200113 || pc_o !== 32'h204) begin bad++; $display("FAIL bp_out_b got=%h pc=%h want=00200113 pc=204", insn_o, pc_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready_drain got=%h want=1", ready_o); end
    step();
    valid_i = 1'b0;
    total++; if (insn_o !== 32'h00300193 || pc_o !== 32'h208 || valid_o !== 1'b1) begin bad++; $display("FAIL bp_out_c got=%h pc=%h v=%h want=00300193 pc=208 v=1", insn_o, pc_o, valid_o); end
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got=%h want=0", valid_o); end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    put(32'h300, 32'h00100093);
    put(32'h304, 32'h00200113);
    valid_i = 1'b1;
    flush_i = 1'b1;
    pc_i    = 32'h308;
    insn_i  = 32'h00300193;
    step();
    valid_i = 1'b0;
    flush_i = 1'b0;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fl_valid got=%h want=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL fl_ready got=%h want=1", ready_o); end
    total++; if (insn_o !== 32'h00000013 || pc_o !== 32'h0) begin bad++; $display("FAIL fl_nop got=%h pc=%h want=00000013 pc=0", insn_o, pc_o); end
    ready_i = 1'b1;
    step();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fl_stays_empty got=%h want=0", valid_o); end
    // Flush with an empty stage and ready_o=1: the incoming insn must still be dropped.
    valid_i = 1'b1;
    flush_i = 1'b1;
    pc_i    = 32'h30C;
    insn_i  = 32'h00400213;
    step();
    valid_i = 1'b0;
    flush_i = 1'b0;
    total++; if (valid_o !== 1'b0 || insn_o !== 32'h00000013) begin bad++; $display("FAIL fl_accept v=%h insn=%h want v=0 insn=00000013", valid_o, insn_o); end
  endtask

  task automatic test_illegal();
    ready_i = 1'b1;
    put(32'h400, 32'h00000000);
    total++; if (illegal_o !== 1'b1 || valid_o !== 1'b1) begin bad++; $display("FAIL ill_zero got=%h v=%h want=1 v=1", illegal_o, valid_o); end
    put(32'h404, 32'h00000033);
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL ill_add got=%h want=0", illegal_o); end
    put(32'h408, 32'h0000007B);
    total++; if (illegal_o !== 1'b1) begin bad++; $display("FAIL ill_opc got=%h want=1", illegal_o); end
    step();
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL ill_novalid got=%h want=0", illegal_o); end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b0;
    put(32'h500, 32'h00100093);
    put(32'h504, 32'h00200113);
    rst     = 1'b1;
    flush_i = 1'b0;
    step();
    rst = 1'b0;
    total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL rm_state v=%h r=%h want v=0 r=1", valid_o, ready_o); end
    ready_i = 1'b1;
    step();
    total++; if (valid_o !== 1'b0 || insn_o !== 32'h00000013) begin bad++; $display("FAIL rm_discard v=%h insn=%h want v=0 insn=00000013", valid_o, insn_o); end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    valid_i = 1'b0;
    pc_i    = '0;
    insn_i  = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    #1;
    test_reset();
    test_decode();
    test_immediates();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
